// File: rtl/a0_trace_buffer.sv
// ---------------------------------------------------------------------------
// a0_trace_buffer
//
// Watches the CPU A0 output register and records every value change as a
// {cycle stamp, A0 value} entry in a small FIFO. The FIFO is drained via a
// first-word-fall-through valid/ready port. A slow consumer therefore does
// not lose A0 updates unless the FIFO fills up. Changes that arrive while the
// FIFO is full are counted and flagged.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous reset, active-low (0 = reset)
//   en         capture enable; while 0, A0 is neither sampled nor compared
//   a0_i       A0 value from the CPU top
//   out_valid  head entry available (count != 0)
//   out_ready  consumer accepts the head entry
//   out_data   A0 value of the head entry
//   out_stamp  cycle stamp of the head entry
//   count      number of stored entries, 0..DEPTH
//   overflow   sticky flag, set when a change is dropped
//   drop_cnt   number of dropped changes, saturates at 255
// ---------------------------------------------------------------------------
module a0_trace_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           a0_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [STAMP_W-1:0]         out_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]   last_a0;
  logic [STAMP_W-1:0] stamp;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;

  logic [WIDTH-1:0]   mem_data  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic chg;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event decode. A pop in the same cycle frees a slot, so a change that
  // arrives while full is still accepted when the consumer is draining.
  always_comb begin
    chg  = en && (a0_i != last_a0);
    full = (count == FULL_CNT);
    pop  = out_valid && out_ready;
    push = chg && (!full || pop);
    drop = chg && full && !pop;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem_data[rptr];
  assign out_stamp = mem_stamp[rptr];

  // Free-running stamp, independent of en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
    end
  end

  // last_a0 follows a0_i whenever capture is enabled, including on drops,
  // so a dropped value is not re-detected on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_a0 <= '0;
    end else if (en) begin
      last_a0 <= a0_i;
    end
  end

  // Entry storage has no reset; it is only ever read while count != 0.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_data[wptr]  <= a0_i;
      mem_stamp[wptr] <= stamp;
    end
  end

  // Pointers wrap naturally at DEPTH; count disambiguates full vs. empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Overflow bookkeeping clears only on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_a0_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_a0_trace_buffer
//
// Directed bench for a0_trace_buffer. Inputs change 1 time unit after each
// rising edge, and outputs are sampled at that same point. stamp_m tracks the
// value held in the DUT stamp counter after each edge.
// ---------------------------------------------------------------------------
module tb_a0_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a0_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  int stamp_m  = 0;
  int s0;

  always #5 clk = ~clk;

  a0_trace_buffer #(.WIDTH(32), .DEPTH(16), .STAMP_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a0_i      (a0_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_stamp (out_stamp),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) stamp_m = 0;
    else      stamp_m = stamp_m + 1;
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    a0_i      = 32'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    en  = 1'b1;

    // 1: idle with a0_i constant at 0
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_val("t1_valid", 32'(out_valid), 32'd0);
    end
    chk_val("t1_count", 32'(count), 32'd0);
    chk_val("t1_overflow", 32'(overflow), 32'd0);
    chk_val("t1_drop_cnt", 32'(drop_cnt), 32'd0);

    // 2: single change at stamp 3, popped on the next edge
    rst = 1'b0;
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    a0_i = 32'd5;
    tick();
    chk_val("t2_valid", 32'(out_valid), 32'd1);
    chk_val("t2_data", out_data, 32'd5);
    chk_val("t2_stamp", 32'(out_stamp), 32'd3);
    tick();
    chk_val("t2_valid_after_pop", 32'(out_valid), 32'd0);
    chk_val("t2_count_after_pop", 32'(count), 32'd0);

    // 3: 20 changes with no consumer; 4 are dropped, then drain 1..16
    out_ready = 1'b0;
    s0 = stamp_m;
    for (int v = 1; v <= 20; v++) begin
      a0_i = 32'(v);
      tick();
    end
    chk_val("t3_count", 32'(count), 32'd16);
    chk_val("t3_head", out_data, 32'd1);
    chk_val("t3_head_stamp", 32'(out_stamp), 32'(s0 & 16'hFFFF));
    chk_val("t3_overflow", 32'(overflow), 32'd1);
    chk_val("t3_drop_cnt", 32'(drop_cnt), 32'd4);
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk_val("t3_drain_valid", 32'(out_valid), 32'd1);
      chk_val("t3_drain_data", out_data, 32'(k));
      chk_val("t3_drain_stamp", 32'(out_stamp), 32'((s0 + k - 1) & 16'hFFFF));
      tick();
    end
    chk_val("t3_empty_valid", 32'(out_valid), 32'd0);
    chk_val("t3_empty_count", 32'(count), 32'd0);

    // 4: full FIFO with a pop and a change in the same cycle
    out_ready = 1'b0;
    for (int v = 0; v < 16; v++) begin
      a0_i = 32'(100 + v);
      tick();
    end
    chk_val("t4_full_count", 32'(count), 32'd16);
    out_ready = 1'b1;
    a0_i      = 32'd116;
    tick();
    chk_val("t4_count", 32'(count), 32'd16);
    chk_val("t4_drop_cnt", 32'(drop_cnt), 32'd4);
    chk_val("t4_overflow", 32'(overflow), 32'd1);
    for (int k = 101; k <= 116; k++) begin
      chk_val("t4_drain_data", out_data, 32'(k));
      tick();
    end
    chk_val("t4_empty_count", 32'(count), 32'd0);

    // 5: changes while en=0 are not captured
    out_ready = 1'b0;
    en        = 1'b0;
    a0_i      = 32'd7;
    tick();
    a0_i = 32'd9;
    tick();
    chk_val("t5_count_disabled", 32'(count), 32'd0);
    en = 1'b1;
    tick();
    chk_val("t5_count", 32'(count), 32'd1);
    chk_val("t5_data", out_data, 32'd9);
    tick();
    chk_val("t5_count_hold", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    chk_val("t5_count_drained", 32'(count), 32'd0);

    // 6: reset mid-drain overrides push and pop
    out_ready = 1'b0;
    for (int v = 0; v < 6; v++) begin
      a0_i = 32'(200 + v);
      tick();
    end
    chk_val("t6_count_fill", 32'(count), 32'd6);
    out_ready = 1'b1;
    tick();
    chk_val("t6_count_mid", 32'(count), 32'd5);
    chk_val("t6_head_mid", out_data, 32'd201);
    a0_i = 32'd210;
    rst  = 1'b0;
    tick();
    chk_val("t6_rst_count", 32'(count), 32'd0);
    chk_val("t6_rst_valid", 32'(out_valid), 32'd0);
    chk_val("t6_rst_overflow", 32'(overflow), 32'd0);
    chk_val("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst       = 1'b1;
    a0_i      = 32'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val("t6_zero_no_entry", 32'(count), 32'd0);
    end
    a0_i = 32'd1;
    tick();
    chk_val("t6_post_count", 32'(count), 32'd1);
    chk_val("t6_post_data", out_data, 32'd1);
    chk_val("t6_post_stamp", 32'(out_stamp), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
